// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multi-cycle RISC-V control sequencer:
// opcode values, ALU operation select codes and FSM state encodings.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_ALU_R     = 7'b0110011;
    localparam logic [6:0] OP_ALU_I     = 7'b0010011;
    localparam logic [6:0] OP_BRANCH_EQ = 7'b1100011;
    localparam logic [6:0] OP_JUMP      = 7'b1101111;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_R_TYPE = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;

    function automatic logic is_known_op(input logic [6:0] op);
        logic known;
        case (op)
            OP_ALU_R, OP_ALU_I, OP_BRANCH_EQ,
            OP_JUMP, OP_LOAD, OP_STORE: known = 1'b1;
            default:                    known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait-state timer.
// Ports:
//   clk, arst_n : clock, async active-low reset
//   clr         : clear count (priority over inc)
//   inc         : count one more wait cycle
//   expired     : count has reached TIMEOUT_MAX
module ctrl_wait_timer
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_MAX = 15
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clr) begin
            wait_cnt_d = 8'd0;
        end else if (inc) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign expired = (wait_cnt_q == 8'(TIMEOUT_MAX));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB control for a shared
// ALU and memory datapath, with ready handshakes, wait timeout and a
// retired-instruction counter.
// Ports:
//   clk, arst_n                  : clock, async active-low reset
//   enable                       : run request (sampled in IDLE / on completion)
//   opcode, zero_flag            : IR opcode, ALU zero result
//   imem_ready, dmem_ready       : memory handshakes
//   imem_req ... reg_write       : datapath controls, decoded from state + op_q
//   instr_done/illegal_op/bus_error : single-cycle event pulses
//   state, instr_count           : debug state, retired count (wraps)
//
// state  | meaning
// IDLE   | waiting for enable
// FETCH  | instruction read, wait for imem_ready
// DECODE | latch opcode, reject unknown ones
// EXEC   | ALU operation / branch / jump
// MEM    | data access, wait for dmem_ready
// WB     | register file write, retire
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_MAX = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             enable,
    input  logic [6:0]       opcode,
    input  logic             zero_flag,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_2_reg,
    output logic             reg_write,
    output logic             instr_done,
    output logic             illegal_op,
    output logic             bus_error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    logic [2:0]       state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wait_inc;
    logic             wait_clr;
    logic             expired;
    logic             retire;

    assign wait_inc = ((state_q == ST_FETCH) && !imem_ready) ||
                      ((state_q == ST_MEM)   && !dmem_ready);
    // Also clear on the expiry cycle: the FSM leaves for IDLE anyway.
    assign wait_clr = !wait_inc || expired;

    ctrl_wait_timer #(
        .TIMEOUT_MAX(TIMEOUT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (wait_clr),
        .inc    (wait_inc),
        .expired(expired)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        retire     = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALUOP_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_2_reg  = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        bus_error  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                // A ready arriving on the expiry cycle still wins.
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (expired) begin
                    bus_error = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DECODE: begin
                op_d = opcode;
                if (is_known_op(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = enable ? ST_FETCH : ST_IDLE;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ALU_R: begin
                        alu_op  = ALUOP_R_TYPE;
                        state_d = ST_WB;
                    end
                    OP_ALU_I: begin
                        alu_op  = ALUOP_R_TYPE;
                        alu_src = 1'b1;
                        state_d = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src = 1'b1;
                        state_d = ST_MEM;
                    end
                    OP_BRANCH_EQ: begin
                        alu_op   = ALUOP_SUB;
                        pc_src   = 1'b1;
                        pc_write = zero_flag;
                        retire   = 1'b1;
                    end
                    OP_JUMP: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        state_d  = ST_WB;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_MEM: begin
                dmem_req  = 1'b1;
                alu_src   = 1'b1;
                mem_read  = (op_q == OP_LOAD);
                mem_write = (op_q == OP_STORE);
                if (dmem_ready) begin
                    if (op_q == OP_LOAD) state_d = ST_WB;
                    else                 retire  = 1'b1;
                end else if (expired) begin
                    bus_error = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                mem_2_reg = (op_q == OP_LOAD);
                retire    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (retire) begin
            instr_done = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            state_d    = enable ? ST_FETCH : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 7'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    localparam logic [14:0] M_IMEM = 15'h4000;
    localparam logic [14:0] M_DMEM = 15'h2000;
    localparam logic [14:0] M_IRW  = 15'h1000;
    localparam logic [14:0] M_PCW  = 15'h0800;
    localparam logic [14:0] M_PCS  = 15'h0400;
    localparam logic [14:0] M_ASRC = 15'h0200;
    localparam logic [14:0] M_AOPR = 15'h0100;
    localparam logic [14:0] M_AOPS = 15'h0080;
    localparam logic [14:0] M_MRD  = 15'h0040;
    localparam logic [14:0] M_MWR  = 15'h0020;
    localparam logic [14:0] M_M2R  = 15'h0010;
    localparam logic [14:0] M_RW   = 15'h0008;
    localparam logic [14:0] M_DONE = 15'h0004;
    localparam logic [14:0] M_ILL  = 15'h0002;
    localparam logic [14:0] M_BERR = 15'h0001;

    localparam logic [14:0] C_FETCH_RDY = M_IMEM | M_IRW | M_PCW;
    localparam logic [14:0] C_MEM_LD    = M_DMEM | M_ASRC | M_MRD;
    localparam logic [14:0] C_MEM_ST    = M_DMEM | M_ASRC | M_MWR;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        enable, zero_flag, imem_ready, dmem_ready;
    logic [6:0]  opcode;

    logic        imem_req, dmem_req, ir_write, pc_write, pc_src, alu_src;
    logic [1:0]  alu_op;
    logic        mem_read, mem_write, mem_2_reg, reg_write;
    logic        instr_done, illegal_op, bus_error;
    logic [2:0]  state;
    logic [31:0] instr_count;

    logic        s_imem_req, s_dmem_req, s_ir_write, s_pc_write, s_pc_src, s_alu_src;
    logic [1:0]  s_alu_op;
    logic        s_mem_read, s_mem_write, s_mem_2_reg, s_reg_write;
    logic        s_instr_done, s_illegal_op, s_bus_error;
    logic [2:0]  s_state;
    logic [1:0]  s_instr_count;

    logic [14:0] ctl, s_ctl;
    assign ctl = {imem_req, dmem_req, ir_write, pc_write, pc_src, alu_src, alu_op,
                  mem_read, mem_write, mem_2_reg, reg_write, instr_done, illegal_op, bus_error};
    assign s_ctl = {s_imem_req, s_dmem_req, s_ir_write, s_pc_write, s_pc_src, s_alu_src, s_alu_op,
                    s_mem_read, s_mem_write, s_mem_2_reg, s_reg_write, s_instr_done,
                    s_illegal_op, s_bus_error};

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.TIMEOUT_MAX(15), .CNT_W(32)) dut (
        .clk(clk), .arst_n(arst_n), .enable(enable), .opcode(opcode),
        .zero_flag(zero_flag), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .mem_2_reg(mem_2_reg),
        .reg_write(reg_write), .instr_done(instr_done), .illegal_op(illegal_op),
        .bus_error(bus_error), .state(state), .instr_count(instr_count)
    );

    // Narrow-counter copy driven identically, to observe counter wrap.
    multicycle_ctrl_fsm #(.TIMEOUT_MAX(15), .CNT_W(2)) u_small (
        .clk(clk), .arst_n(arst_n), .enable(enable), .opcode(opcode),
        .zero_flag(zero_flag), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(s_imem_req), .dmem_req(s_dmem_req), .ir_write(s_ir_write),
        .pc_write(s_pc_write), .pc_src(s_pc_src), .alu_src(s_alu_src), .alu_op(s_alu_op),
        .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_2_reg(s_mem_2_reg),
        .reg_write(s_reg_write), .instr_done(s_instr_done), .illegal_op(s_illegal_op),
        .bus_error(s_bus_error), .state(s_state), .instr_count(s_instr_count)
    );

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [14:0] ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ec       = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] st, input logic [14:0] c);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.ctl = c;
        e.cnt = ec;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_state"}, 32'(state), 32'(e.st));
            chk({e.tag, "_ctl"},   32'(ctl),   32'(e.ctl));
            chk({e.tag, "_cnt"},   instr_count, e.cnt);
            chk({e.tag, "_sstate"}, 32'(s_state), 32'(e.st));
            chk({e.tag, "_sctl"},   32'(s_ctl),   32'(e.ctl));
            chk({e.tag, "_scnt"},   32'(s_instr_count), 32'(e.cnt[1:0]));
        end
    endtask

    // One clock: drive inputs, record expectation, compare at negedge.
    task automatic cyc(input string tag, input logic en, input logic ir, input logic dr,
                       input logic zf, input logic [2:0] st, input logic [14:0] c);
        enable     = en;
        imem_ready = ir;
        dmem_ready = dr;
        zero_flag  = zf;
        push_exp(tag, st, c);
        @(negedge clk);
        pop_cmp();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n = 1'b0; enable = 1'b0; zero_flag = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; opcode = 7'd0;
        #2;
        push_exp("reset", 3'd0, 15'd0);
        pop_cmp();
        @(posedge clk); #1;
        arst_n = 1'b1;

        // ADD, zero-wait
        cyc("add_idle",  1, 0, 0, 0, 3'd0, 15'd0);
        cyc("add_fetch", 1, 1, 0, 0, 3'd1, C_FETCH_RDY);
        opcode = 7'b0110011;
        cyc("add_dec",   1, 0, 0, 0, 3'd2, 15'd0);
        cyc("add_exec",  1, 0, 0, 0, 3'd3, M_AOPR);
        cyc("add_wb",    1, 0, 0, 0, 3'd5, M_RW | M_DONE);
        ec++;

        // LOAD with 3 dmem wait cycles
        cyc("ld_fetch",  1, 1, 0, 0, 3'd1, C_FETCH_RDY);
        opcode = 7'b0000011;
        cyc("ld_dec",    1, 0, 0, 0, 3'd2, 15'd0);
        cyc("ld_exec",   1, 0, 0, 0, 3'd3, M_ASRC);
        for (int i = 0; i < 3; i++) cyc("ld_mem_wait", 1, 0, 0, 0, 3'd4, C_MEM_LD);
        cyc("ld_mem_rdy", 1, 0, 1, 0, 3'd4, C_MEM_LD);
        cyc("ld_wb",     1, 0, 0, 0, 3'd5, M_RW | M_M2R | M_DONE);
        ec++;

        // BRANCH_EQ taken then not taken
        cyc("beq1_fetch", 1, 1, 0, 0, 3'd1, C_FETCH_RDY);
        opcode = 7'b1100011;
        cyc("beq1_dec",   1, 0, 0, 0, 3'd2, 15'd0);
        cyc("beq1_exec",  1, 0, 0, 1, 3'd3, M_AOPS | M_PCS | M_PCW | M_DONE);
        ec++;
        cyc("beq0_fetch", 1, 1, 0, 0, 3'd1, C_FETCH_RDY);
        cyc("beq0_dec",   1, 0, 0, 0, 3'd2, 15'd0);
        cyc("beq0_exec",  1, 0, 0, 0, 3'd3, M_AOPS | M_PCS | M_DONE);
        ec++;

        // imem timeout: error on the 16th FETCH cycle
        for (int i = 0; i < 15; i++) cyc("to_wait", 1, 0, 0, 0, 3'd1, M_IMEM);
        cyc("to_err",  1, 0, 0, 0, 3'd1, M_IMEM | M_BERR);
        cyc("to_idle", 1, 0, 0, 0, 3'd0, 15'd0);

        // Ready on the 16th cycle wins over timeout
        for (int i = 0; i < 15; i++) cyc("late_wait", 1, 0, 0, 0, 3'd1, M_IMEM);
        cyc("late_rdy", 1, 1, 0, 0, 3'd1, C_FETCH_RDY);
        opcode = 7'b1111111;
        cyc("ill_dec",  1, 0, 0, 0, 3'd2, M_ILL);

        // JUMP with enable dropped mid-instruction
        cyc("jmp_fetch", 1, 1, 0, 0, 3'd1, C_FETCH_RDY);
        opcode = 7'b1101111;
        cyc("jmp_dec",   1, 1, 1, 0, 3'd2, 15'd0);
        cyc("jmp_exec",  0, 1, 1, 0, 3'd3, M_PCW | M_PCS);
        cyc("jmp_wb",    0, 0, 0, 0, 3'd5, M_RW | M_DONE);
        ec++;
        cyc("jmp_idle0", 0, 1, 1, 0, 3'd0, 15'd0);
        cyc("jmp_idle1", 1, 0, 0, 0, 3'd0, 15'd0);

        // STORE interrupted by reset in MEM
        cyc("st_fetch", 1, 1, 0, 0, 3'd1, C_FETCH_RDY);
        opcode = 7'b0100011;
        cyc("st_dec",   1, 0, 0, 0, 3'd2, 15'd0);
        cyc("st_exec",  1, 0, 1, 0, 3'd3, M_ASRC);
        cyc("st_mem",   1, 1, 0, 0, 3'd4, C_MEM_ST);
        dmem_ready = 1'b1;
        arst_n = 1'b0;
        #1;
        ec = 32'd0;
        push_exp("st_rst", 3'd0, 15'd0);
        pop_cmp();
        @(posedge clk); #1;
        push_exp("st_rst_hold", 3'd0, 15'd0);
        pop_cmp();
        arst_n = 1'b1;
        cyc("post_idle",  1, 0, 0, 0, 3'd0, 15'd0);
        cyc("post_fetch", 1, 1, 0, 0, 3'd1, C_FETCH_RDY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multi-cycle sequencer for the RISC-V datapath. It replaces single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine, so the ALU and memory are shared across cycles. It handles memory wait-states with ready handshakes and a timeout, and it counts retired instructions. It sits between the instruction register, the register file, the ALU and the memory ports.

Parameters:
TIMEOUT_MAX, 15, max wait cycles for imem_ready/dmem_ready before bus error (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
arst_n  in  1  asynchronous active-low reset
enable  in  1  run request; sampled only in IDLE and at instruction completion
opcode  in  7  instruction opcode from IR; valid from DECODE onward
zero_flag  in  1  ALU zero result
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
ir_write  out  1  load IR
pc_write  out  1  update PC
pc_src  out  1  0 = PC+4, 1 = branch/jump target
alu_src  out  1  0 = register operand, 1 = immediate
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
mem_read  out  1  load access
mem_write  out  1  store access
mem_2_reg  out  1  writeback source is memory
reg_write  out  1  register file write enable
instr_done  out  1  one-cycle pulse on retirement
illegal_op  out  1  one-cycle pulse on unknown opcode
bus_error  out  1  one-cycle pulse on memory timeout
state  out  3  current state, for debug
instr_count  out  CNT_W  retired instructions, wraps to 0

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- Reset (arst_n=0, asynchronous): state=IDLE, op_q=0, wait_cnt=0, instr_count=0. All outputs 0.
- Reset mid-instruction aborts the instruction immediately. No instr_done is generated.
- Control outputs are decoded combinationally from the state and the latched op_q. The pulses (instr_done, illegal_op, bus_error) are asserted in the cycle in which the completing transition occurs.
- Opcodes: ALU_R=0110011, ALU_I=0010011, BRANCH_EQ=1100011, JUMP=1101111, LOAD=0000011, STORE=0100011.
- IDLE: if enable=1, go to FETCH; otherwise stay.
- FETCH:
  - imem_req=1, alu_op=00.
  - When imem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE:
  - Latch op_q<=opcode.
  - Known opcode: go to EXEC.
  - Unknown opcode: illegal_op=1, no retirement, go to FETCH if enable=1, else IDLE.
- EXEC:
  - ALU_R: alu_op=10, alu_src=0, go to WB.
  - ALU_I: alu_op=10, alu_src=1, go to WB.
  - LOAD/STORE: alu_op=00, alu_src=1, go to MEM.
  - BRANCH_EQ: alu_op=01, alu_src=0, pc_src=1, pc_write=zero_flag. Retire.
  - JUMP: pc_write=1, pc_src=1, go to WB (link write).
- MEM:
  - dmem_req=1, alu_src=1, alu_op=00, mem_read=(LOAD), mem_write=(STORE). These are held stable until dmem_ready=1.
  - On ready: LOAD goes to WB; STORE retires.
- WB: reg_write=1, mem_2_reg=(op_q==LOAD). Retire.
- Retire:
  - instr_done=1 and instr_count+1 (mod 2^CNT_W).
  - Next state is FETCH if enable=1, else IDLE.
- Timeout:
  - wait_cnt increments each cycle in FETCH/MEM while the corresponding ready=0, and clears on leaving the state.
  - If ready is still 0 when wait_cnt==TIMEOUT_MAX: bus_error=1, go to IDLE, instruction not retired.
  - Ready arriving in that same cycle wins; no error is raised.
- enable dropping mid-instruction does not abort. The current instruction completes, then the FSM goes to IDLE.
- imem_ready in a non-FETCH state and dmem_ready outside MEM are ignored.

Decomposition:
- Shared package (riscv_ctrl_pkg):
  - opcode constants.
  - ALUOp constants (ADD 00, SUB 01, R_TYPE 10).
  - state encoding localparams.
- Sub-module: ctrl_wait_timer (wait_cnt with clear/inc/expire). Everything else stays in one FSM module.

Test Plan:
- Reset then enable=1, ADD (0110011), zero-wait memories → states 1,2,3,5; instr_done in the 4th cycle after FETCH entry; instr_count=1; reg_write=1 only in WB.
- LOAD with dmem_ready delayed 3 cycles → mem_read/dmem_req held 4 cycles; WB has mem_2_reg=1; instr_done once.
- BRANCH_EQ with zero_flag=1, then repeated with zero_flag=0 → pc_write=1, pc_src=1 in EXEC for the first; pc_write=0 for the second; both retire.
- imem_ready held 0 with TIMEOUT_MAX=15 → bus_error pulse 16 cycles after FETCH entry, state=IDLE, instr_count unchanged. Ready asserted in the 16th cycle → no error.
- Opcode 1111111 → illegal_op pulse in DECODE, no instr_done, return to FETCH.
- arst_n pulsed low during MEM of a STORE → all outputs 0 immediately, instr_count=0, state=IDLE. With instr_count preset near 2^CNT_W-1 (small CNT_W build), the counter wraps to 0.
